framebuffer_scanout: RTL and testbench

FRAMEBUFFER_SCANOUT -- requirements
Module: framebuffer_scanout

---
 rtl/framebuffer_scanout.sv | 149 ++++++++++++++
 tb/tb_framebuffer_scanout.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/framebuffer_scanout.sv
// Scans a 512x512 1-bit-per-colour framebuffer out as a pixel stream.
// A two-entry word buffer is fed by single outstanding reads of fixed latency.
module framebuffer_scanout #(
  parameter int RD_LATENCY = 2,
  parameter int WORDS      = 1024
) (
  input  logic         clock,
  input  logic         clr,
  input  logic         frame_start,
  output logic [9:0]   address_b,
  input  logic [255:0] sreds,
  input  logic [255:0] sgreens,
  input  logic [255:0] sblues,
  output logic         pix_valid,
  input  logic         pix_ready,
  output logic         pix_r,
  output logic         pix_g,
  output logic         pix_b,
  output logic [8:0]   pix_x,
  output logic [8:0]   pix_y,
  output logic         pix_eol,
  output logic         pix_eof,
  output logic         busy,
  output logic         frame_done
);

  // state   | meaning
  // IDLE    | waiting for frame_start
  // PREFILL | first read in flight, nothing to show yet
  // STREAM  | emitting pixels, more words still to fetch
  // DRAIN   | all words fetched, emitting the remainder
  typedef enum logic [1:0] {IDLE, PREFILL, STREAM, DRAIN} state_t;

  localparam int LW = $clog2(RD_LATENCY) + 1;
  localparam int NW = $clog2(WORDS + 1);

  state_t         state, state_nxt;
  logic           inflight;
  logic [LW-1:0]  lat_cnt;
  logic [NW-1:0]  rd_next;
  logic [1:0]     filled, filled_nxt;
  logic           head, wr_ptr;
  logic [9:0]     out_word;
  logic [7:0]     bit_idx;
  logic [255:0]   buf_r [2];
  logic [255:0]   buf_g [2];
  logic [255:0]   buf_b [2];
  logic           start, capture, last_cap, read_ok, issue, xfer, word_end, last_pix;

  assign start    = (state == IDLE) && frame_start;
  assign capture  = inflight && (lat_cnt == '0);
  assign last_cap = capture && (address_b == 10'(WORDS - 1));
  assign issue    = read_ok && !inflight && (filled != 2'b11) && (rd_next < NW'(WORDS));
  assign xfer     = pix_valid && pix_ready;
  assign word_end = xfer && (bit_idx == 8'hff);
  assign last_pix = word_end && (out_word == 10'(WORDS - 1));

  always_ff @(posedge clock or posedge clr) begin
    if (clr) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (frame_start) state_nxt = PREFILL;
      PREFILL: if (capture)     state_nxt = last_cap ? DRAIN : STREAM;
      STREAM:  if (last_cap)    state_nxt = DRAIN;
      DRAIN:   if (last_pix)    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    read_ok   = (state == PREFILL) || (state == STREAM);
    pix_valid = ((state == STREAM) || (state == DRAIN)) && filled[head];
  end

  // A free of the head and a capture into the tail may land in the same cycle.
  always_comb begin
    filled_nxt = filled;
    if (word_end) filled_nxt[head]   = 1'b0;
    if (capture)  filled_nxt[wr_ptr] = 1'b1;
  end

  always_ff @(posedge clock or posedge clr) begin
    if (clr) begin
      address_b  <= '0;
      inflight   <= 1'b0;
      lat_cnt    <= '0;
      rd_next    <= '0;
      filled     <= '0;
      head       <= 1'b0;
      wr_ptr     <= 1'b0;
      out_word   <= '0;
      bit_idx    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= (state == DRAIN) && last_pix;
      if (start) begin
        address_b <= '0;
        inflight  <= 1'b1;
        lat_cnt   <= LW'(RD_LATENCY - 1);
        rd_next   <= NW'(1);
        filled    <= '0;
        head      <= 1'b0;
        wr_ptr    <= 1'b0;
        out_word  <= '0;
        bit_idx   <= '0;
      end else begin
        if (issue) begin
          address_b <= 10'(rd_next);
          rd_next   <= rd_next + NW'(1);
          inflight  <= 1'b1;
          lat_cnt   <= LW'(RD_LATENCY - 1);
        end else if (inflight) begin
          if (lat_cnt == '0) inflight <= 1'b0;
          else               lat_cnt  <= lat_cnt - LW'(1);
        end
        filled <= filled_nxt;
        if (capture) wr_ptr  <= ~wr_ptr;
        if (xfer)    bit_idx <= bit_idx + 8'd1;
        if (word_end) begin
          head     <= ~head;
          out_word <= out_word + 10'd1;
        end
      end
    end
  end

  // Word storage carries no reset; the filled flags alone decide validity.
  always_ff @(posedge clock) begin
    if (capture) begin
      buf_r[wr_ptr] <= sreds;
      buf_g[wr_ptr] <= sgreens;
      buf_b[wr_ptr] <= sblues;
    end
  end

  assign pix_r   = pix_valid & buf_r[head][bit_idx];
  assign pix_g   = pix_valid & buf_g[head][bit_idx];
  assign pix_b   = pix_valid & buf_b[head][bit_idx];
  assign pix_x   = {out_word[0], bit_idx};
  assign pix_y   = out_word[9:1];
  assign pix_eol = &pix_x;
  assign pix_eof = pix_eol & (&pix_y);

endmodule

// File: tb/tb_framebuffer_scanout.sv
// Scoreboard bench: one scanout with a short frame under mixed stimulus,
// and a slow-memory scanout held stalled to observe read throttling.
module tb_framebuffer_scanout;

  localparam int LAT_A = 2;
  localparam int WA    = 32;
  localparam int PA    = WA * 256;
  localparam int LAT_B = 4;
  localparam int WB    = 4;
  localparam int PB    = WB * 256;

  logic         clk;
  logic         clr, frame_start, pix_ready;
  logic [9:0]   address_b;
  logic [255:0] sreds, sgreens, sblues;
  logic         pix_valid, pix_r, pix_g, pix_b, pix_eol, pix_eof, busy, frame_done;
  logic [8:0]   pix_x, pix_y;

  logic         b_clr, b_frame_start, b_ready;
  logic [9:0]   b_address;
  logic [255:0] b_sreds, b_sgreens, b_sblues;
  logic         b_valid, b_r, b_g, b_b, b_eol, b_eof, b_busy, b_done;
  logic [8:0]   b_x, b_y;

  int total = 0;
  int bad   = 0;
  logic [22:0] exp_q[$];
  int  xfer_cnt = 0;
  int  done_cnt = 0;
  int  exp_done = 0;
  int  rdy_mode = 0;
  bit  gap_mode = 0;
  bit  b_fin    = 0;

  framebuffer_scanout #(.RD_LATENCY(LAT_A), .WORDS(WA)) dut_a (
    .clock(clk), .clr(clr), .frame_start(frame_start), .address_b(address_b),
    .sreds(sreds), .sgreens(sgreens), .sblues(sblues),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b), .pix_x(pix_x), .pix_y(pix_y),
    .pix_eol(pix_eol), .pix_eof(pix_eof), .busy(busy), .frame_done(frame_done)
  );

  framebuffer_scanout #(.RD_LATENCY(LAT_B), .WORDS(WB)) dut_b (
    .clock(clk), .clr(b_clr), .frame_start(b_frame_start), .address_b(b_address),
    .sreds(b_sreds), .sgreens(b_sgreens), .sblues(b_sblues),
    .pix_valid(b_valid), .pix_ready(b_ready),
    .pix_r(b_r), .pix_g(b_g), .pix_b(b_b), .pix_x(b_x), .pix_y(b_y),
    .pix_eol(b_eol), .pix_eof(b_eof), .busy(b_busy), .frame_done(b_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory contents: red word a is a repeated, green is its complement, blue is 0.
  function automatic logic [255:0] mem_r(input logic [9:0] a);
    logic [255:0] v;
    for (int n = 0; n < 256; n++) v[n] = a[n % 10];
    return v;
  endfunction

  // Expected pixel p of a frame: {r,g,b,x,y,eol,eof}.
  function automatic logic [22:0] exp_pix(input int p);
    int a, n, x, y;
    logic [9:0] av;
    logic r;
    a  = p / 256;
    n  = p % 256;
    x  = 256 * (a % 2) + n;
    y  = a / 2;
    av = 10'(a);
    r  = av[n % 10];
    return {r, ~r, 1'b0, 9'(x), 9'(y), (x == 511), (x == 511 && y == 511)};
  endfunction

  task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Memory models: data for address_b appears RD_LATENCY edges after it changes.
  logic [9:0] hist_a;
  logic [9:0] hist_b [3];
  always @(posedge clk) begin
    hist_a    <= address_b;
    hist_b[0] <= b_address;
    hist_b[1] <= hist_b[0];
    hist_b[2] <= hist_b[1];
  end
  assign sreds     = mem_r(hist_a);
  assign sgreens   = ~mem_r(hist_a);
  assign sblues    = '0;
  assign b_sreds   = mem_r(hist_b[LAT_B - 2]);
  assign b_sgreens = ~mem_r(hist_b[LAT_B - 2]);
  assign b_sblues  = '0;

  always @(posedge clk) begin
    #1;
    pix_ready = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
  end

  logic [22:0] prev_pix;
  logic [9:0]  last_addr;
  bit          prev_stall = 0;
  bit          prev_busy  = 0;
  bit          seen_valid = 0;

  always @(negedge clk) begin : mon
    logic [22:0] cur, e;
    cur = {pix_r, pix_g, pix_b, pix_x, pix_y, pix_eol, pix_eof};
    if (clr) begin
      prev_stall = 0;
      prev_busy  = 0;
      seen_valid = 0;
      last_addr  = address_b;
    end else begin
      if (busy && !prev_busy) begin
        seen_valid = 0;
        chk(address_b == 10'd0, "addr_start", 64'(address_b), 64'd0);
      end else if (busy && address_b != last_addr) begin
        chk(address_b == last_addr + 10'd1, "addr_step", 64'(address_b), 64'(last_addr + 10'd1));
      end
      if (prev_stall)
        chk(pix_valid && cur == prev_pix, "stall_hold", 64'({pix_valid, cur}), 64'({1'b1, prev_pix}));
      if (gap_mode && busy && seen_valid && exp_q.size() > 0)
        chk(pix_valid, "valid_gap", 64'(pix_valid), 64'd1);
      if (pix_valid && pix_ready) begin
        if (exp_q.size() == 0) chk(1'b0, "extra_pixel", 64'(cur), 64'd0);
        else begin
          e = exp_q.pop_front();
          chk(cur == e, "pixel", 64'(cur), 64'(e));
        end
        xfer_cnt++;
      end
      if (frame_done) begin
        done_cnt++;
        chk(!busy && !pix_valid && exp_q.size() == 0, "done_state",
            64'({busy, pix_valid, 8'(exp_q.size())}), 64'd0);
      end
      if (pix_valid) seen_valid = 1;
      prev_stall = pix_valid && !pix_ready;
      prev_pix   = cur;
      prev_busy  = busy;
      last_addr  = address_b;
    end
  end

  task automatic start_frame(input bit expect_run);
    @(negedge clk); #1;
    if (expect_run) begin
      for (int p = 0; p < PA; p++) exp_q.push_back(exp_pix(p));
      exp_done++;
    end
    frame_start = 1'b1;
    @(negedge clk); #1;
    frame_start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int c;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!frame_done && c < 4 * PA);
    chk(frame_done, nm, 64'(c), 64'(4 * PA));
  endtask

  task automatic wait_pixels(input int base, input int n);
    int c;
    c = 0;
    while (xfer_cnt < base + n && c < 4 * n) begin
      @(negedge clk);
      c++;
    end
    chk(xfer_cnt >= base + n, "progress", 64'(xfer_cnt - base), 64'(n));
  endtask

  // Main stimulus for the short-frame instance.
  initial begin
    int x0, c;
    clr = 1'b1;
    frame_start = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk({address_b, pix_valid, pix_r, pix_g, pix_b, pix_x, pix_y, pix_eol, pix_eof, busy, frame_done} == '0,
        "reset_state", 64'({address_b, pix_valid, pix_x, pix_y, busy}), 64'd0);
    clr = 1'b0;

    // Full frame with ready held high; first pixel latency and no gaps.
    rdy_mode = 0; gap_mode = 1; x0 = xfer_cnt;
    start_frame(1'b1);
    c = 1;
    while (!pix_valid && c < 20) begin
      @(negedge clk);
      c++;
    end
    chk(c >= 3 && c <= 4, "first_valid_latency", 64'(c), 64'd3);
    chk({pix_x, pix_y, pix_r} == '0, "first_pixel", 64'({pix_x, pix_y, pix_r}), 64'd0);
    wait_done("frame1_done");
    chk(xfer_cnt - x0 == PA, "frame1_count", 64'(xfer_cnt - x0), 64'(PA));
    @(negedge clk);
    chk(!busy && !pix_valid, "idle_after", 64'({busy, pix_valid}), 64'd0);

    // Same frame under random back-pressure.
    rdy_mode = 1; gap_mode = 0; x0 = xfer_cnt;
    start_frame(1'b1);
    wait_done("frame2_done");
    chk(xfer_cnt - x0 == PA, "frame2_count", 64'(xfer_cnt - x0), 64'(PA));

    // frame_start during a scan must be ignored.
    rdy_mode = 0; gap_mode = 1; x0 = xfer_cnt;
    start_frame(1'b1);
    wait_pixels(x0, 1000);
    @(negedge clk); #1 frame_start = 1'b1;
    @(negedge clk); #1 frame_start = 1'b0;
    wait_done("frame3_done");
    chk(xfer_cnt - x0 == PA, "frame3_count", 64'(xfer_cnt - x0), 64'(PA));

    // Abort a frame with clr.
    x0 = xfer_cnt;
    start_frame(1'b0);
    for (int p = 0; p < PA; p++) exp_q.push_back(exp_pix(p));
    wait_pixels(x0, 7000);
    @(negedge clk); #1;
    clr = 1'b1;
    #1;
    chk({address_b, pix_valid, pix_r, pix_g, pix_b, pix_x, pix_y, pix_eol, pix_eof, busy, frame_done} == '0,
        "clr_outputs", 64'({address_b, pix_valid, pix_x, pix_y, busy}), 64'd0);
    exp_q.delete();
    @(negedge clk);
    @(posedge clk); #1;
    clr = 1'b0;

    // Restart after abort begins at word 0.
    rdy_mode = 1; gap_mode = 0; x0 = xfer_cnt;
    start_frame(1'b1);
    wait_done("frame5_done");
    chk(xfer_cnt - x0 == PA, "frame5_count", 64'(xfer_cnt - x0), 64'(PA));
    repeat (4) @(negedge clk);
    chk(done_cnt == exp_done, "frame_done_count", 64'(done_cnt), 64'(exp_done));

    wait (b_fin);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Slow-memory instance: long stall must throttle reads at two words.
  initial begin
    int c, p, max_addr;
    logic [22:0] cur;
    b_clr = 1'b1;
    b_frame_start = 1'b0;
    b_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1 b_clr = 1'b0;
    @(negedge clk); #1 b_frame_start = 1'b1;
    @(negedge clk); #1 b_frame_start = 1'b0;
    c = 0;
    while (!b_valid && c < 50) begin
      @(negedge clk);
      c++;
    end
    chk(b_valid, "b_first_valid", 64'(c), 64'd50);
    max_addr = 0;
    repeat (600) begin
      @(negedge clk);
      if (int'(b_address) > max_addr) max_addr = int'(b_address);
    end
    chk(b_address == 10'd1 && max_addr == 1, "b_addr_stall", 64'(max_addr), 64'd1);
    chk(b_valid && b_busy, "b_valid_held", 64'({b_valid, b_busy}), 64'd3);
    c = 0;
    p = 0;
    while (p < PB && c < 3 * PB) begin
      if (b_valid) begin
        cur = {b_r, b_g, b_b, b_x, b_y, b_eol, b_eof};
        chk(cur == exp_pix(p), "b_pixel", 64'(cur), 64'(exp_pix(p)));
        p++;
      end
      b_ready = 1'b1;
      @(negedge clk);
      c++;
    end
    chk(p == PB, "b_pixel_count", 64'(p), 64'(PB));
    c = 0;
    while (!b_done && c < 5) begin
      @(negedge clk);
      c++;
    end
    chk(b_done && !b_busy && !b_valid, "b_frame_done", 64'({b_done, b_busy, b_valid}), 64'd4);
    b_fin = 1;
  end

endmodule
